fp_compare_pipe: RTL and testbench

//  Pipelined, multi-mode comparator for FloPoCo-format floats {exn[1:0],sign,exp[WE-1:0],frac[WF-1:0]}.

---
 rtl/fp_cmp_pkg.sv | 72 +++++++
 rtl/fp_cmp_core.sv | 93 +++++++++
 rtl/fp_compare_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// -----------------------------------------------------------------------------
// fp_cmp_pkg
// Shared definitions for the FloPoCo-format float comparator.
//   Operand layout (MSB..LSB): {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
//   - exception-class encodings (exn field)
//   - magnitude-class encodings used as the top of the ordering key
//   - relation (mode) encodings
//   - helpers: exn -> key class, and ordering-flags -> relation decode
// -----------------------------------------------------------------------------
package fp_cmp_pkg;

    // exn field encodings
    localparam logic [1:0] EXN_ZERO = 2'b00;
    localparam logic [1:0] EXN_NORM = 2'b01;
    localparam logic [1:0] EXN_INF  = 2'b10;
    localparam logic [1:0] EXN_NAN  = 2'b11;

    // Magnitude class placed at the top of the ordering key so that
    // zero < any normal < infinity holds by plain unsigned compare.
    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;

    // Relation selected per transaction (A rel B)
    typedef enum logic [2:0] {
        MODE_LT    = 3'd0,
        MODE_LE    = 3'd1,
        MODE_EQ    = 3'd2,
        MODE_GE    = 3'd3,
        MODE_GT    = 3'd4,
        MODE_NE    = 3'd5,
        MODE_UNORD = 3'd6,
        MODE_ORD   = 3'd7
    } cmp_mode_e;

    // Map the exn field onto the key class. NaN never reaches a key
    // compare (it short-circuits to unordered), so it shares the default.
    function automatic logic [1:0] exn_to_cls(input logic [1:0] exn);
        logic [1:0] cls;
        case (exn)
            EXN_ZERO: cls = CLS_ZERO;
            EXN_NORM: cls = CLS_NORM;
            EXN_INF:  cls = CLS_INF;
            default:  cls = CLS_ZERO;
        endcase
        return cls;
    endfunction

    // Turn raw ordering flags into the requested relation. Because
    // lt/eq/gt are all 0 when unordered, LT/LE/EQ/GE/GT come out 0 and
    // NE (= ~eq) comes out 1 for NaN inputs without special casing.
    function automatic logic rel_decode(input logic [2:0] mode,
                                        input logic       lt,
                                        input logic       eq,
                                        input logic       gt,
                                        input logic       unord);
        logic res;
        case (cmp_mode_e'(mode))
            MODE_LT:    res = lt;
            MODE_LE:    res = lt | eq;
            MODE_EQ:    res = eq;
            MODE_GE:    res = gt | eq;
            MODE_GT:    res = gt;
            MODE_NE:    res = ~eq;
            MODE_UNORD: res = unord;
            MODE_ORD:   res = ~unord;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// -----------------------------------------------------------------------------
// fp_cmp_core
// Purely combinational compare of two FloPoCo floats by direct field
// inspection (no subtractor).
// Ports:
//   a, b   in  WE+WF+3  operands {exn, sign, exp, frac}
//   lt     out 1        a <  b (0 when unordered)
//   eq     out 1        a == b (0 when unordered; +0 == -0)
//   gt     out 1        a >  b (0 when unordered)
//   unord  out 1        either operand is NaN
// -----------------------------------------------------------------------------
module fp_cmp_core
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 12
) (
    input  logic [WE+WF+2:0] a,
    input  logic [WE+WF+2:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             unord
);

    localparam int KW = WE + WF + 2;   // key width: class + exp + frac

    logic [1:0]    exn_a_s;
    logic [1:0]    exn_b_s;
    logic          nan_a_s;
    logic          nan_b_s;
    logic          neg_a_s;
    logic          neg_b_s;
    logic [KW-1:0] key_a_s;
    logic [KW-1:0] key_b_s;
    logic          mag_lt_s;

    // Classify each operand and build its unsigned magnitude key
    always_comb begin
        exn_a_s = a[WE+WF+2:WE+WF+1];
        exn_b_s = b[WE+WF+2:WE+WF+1];
        nan_a_s = (exn_a_s == EXN_NAN);
        nan_b_s = (exn_b_s == EXN_NAN);

        // A zero behaves as positive so that +0 and -0 land on the same
        // side of the sign test and then compare equal by key.
        neg_a_s = a[WE+WF] & (exn_a_s != EXN_ZERO);
        neg_b_s = b[WE+WF] & (exn_b_s != EXN_ZERO);

        key_a_s = {exn_to_cls(exn_a_s), a[WE+WF-1:0]};
        key_b_s = {exn_to_cls(exn_b_s), b[WE+WF-1:0]};

        // Only normals carry a meaningful exp/frac; zero and infinity
        // payload bits are cleared so equal classes always compare equal.
        if (exn_a_s != EXN_NORM) begin
            key_a_s[WE+WF-1:0] = {(WE+WF){1'b0}};
        end else begin
            key_a_s[WE+WF-1:0] = a[WE+WF-1:0];
        end
        if (exn_b_s != EXN_NORM) begin
            key_b_s[WE+WF-1:0] = {(WE+WF){1'b0}};
        end else begin
            key_b_s[WE+WF-1:0] = b[WE+WF-1:0];
        end

        mag_lt_s = (key_a_s < key_b_s);
    end

    // Resolve ordering: NaN first, then sign, then magnitude key
    always_comb begin
        lt    = 1'b0;
        eq    = 1'b0;
        gt    = 1'b0;
        unord = nan_a_s | nan_b_s;
        if (unord) begin
            lt = 1'b0;
            eq = 1'b0;
            gt = 1'b0;
        end else if (neg_a_s != neg_b_s) begin
            // The negative operand is the smaller one
            lt = neg_a_s;
            gt = neg_b_s;
        end else if (key_a_s == key_b_s) begin
            eq = 1'b1;
        end else if (mag_lt_s ^ neg_a_s) begin
            // Both negative reverses the magnitude ordering
            lt = 1'b1;
        end else begin
            gt = 1'b1;
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// -----------------------------------------------------------------------------
// fp_compare_pipe
// Pipelined multi-relation float comparator with tag pass-through, global
// stall and a saturating count of unordered results.
// Ports:
//   clk, rst_n          clock (rising) / synchronous active-low reset
//   stall               freeze every register, inputs ignored
//   in_valid            accept when in_valid & ~stall
//   in_a, in_b          operands {exn, sign, exp, frac}, W = WE+WF+3 bits
//   in_mode             relation select (see cmp_mode_e)
//   in_tag              user tag returned with the result
//   cnt_clr             clear nan_cnt (beats a same-cycle increment)
//   out_valid           result valid, LAT unstalled cycles after accept
//   out_result          selected relation
//   out_lt/eq/gt        raw ordering flags
//   out_unord           either operand NaN
//   out_tag             tag of this result
//   nan_cnt             saturating count of unordered results leaving pipe
// -----------------------------------------------------------------------------
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE   = 11,
    parameter int WF   = 12,
    parameter int LAT  = 2,
    parameter int TAGW = 4,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                in_valid,
    input  logic [WE+WF+2:0]    in_a,
    input  logic [WE+WF+2:0]    in_b,
    input  logic [2:0]          in_mode,
    input  logic [TAGW-1:0]     in_tag,
    input  logic                cnt_clr,
    output logic                out_valid,
    output logic                out_result,
    output logic                out_lt,
    output logic                out_eq,
    output logic                out_gt,
    output logic                out_unord,
    output logic [TAGW-1:0]     out_tag,
    output logic [CNTW-1:0]     nan_cnt
);

    // One pipeline slot. The relation is decoded as the compare is
    // registered in stage 1, so later stages only need to carry the
    // decoded result instead of the mode.
    typedef struct packed {
        logic            result;
        logic            lt;
        logic            eq;
        logic            gt;
        logic            unord;
        logic [TAGW-1:0] tag;
    } stage_t;

    localparam stage_t STAGE_ZERO = '{
        result: 1'b0,
        lt:     1'b0,
        eq:     1'b0,
        gt:     1'b0,
        unord:  1'b0,
        tag:    {TAGW{1'b0}}
    };

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic                core_lt_s;
    logic                core_eq_s;
    logic                core_gt_s;
    logic                core_unord_s;

    logic [LAT-1:0]      vld_d;
    logic [LAT-1:0]      vld_q;
    stage_t              stg_d [LAT];
    stage_t              stg_q [LAT];

    logic [CNTW-1:0]     nan_cnt_d;
    logic [CNTW-1:0]     nan_cnt_q;
    logic                cnt_inc_s;
    logic                cnt_sat_s;

    fp_cmp_core #(
        .WE (WE),
        .WF (WF)
    ) u_core (
        .a     (in_a),
        .b     (in_b),
        .lt    (core_lt_s),
        .eq    (core_eq_s),
        .gt    (core_gt_s),
        .unord (core_unord_s)
    );

    // Next state of the stage/delay registers: shift on every unstalled cycle
    always_comb begin
        vld_d = vld_q;
        stg_d = stg_q;
        if (!stall) begin
            // A non-valid input still shifts in, as a bubble
            vld_d[0]        = in_valid;
            stg_d[0].result = rel_decode(in_mode, core_lt_s, core_eq_s,
                                         core_gt_s, core_unord_s);
            stg_d[0].lt     = core_lt_s;
            stg_d[0].eq     = core_eq_s;
            stg_d[0].gt     = core_gt_s;
            stg_d[0].unord  = core_unord_s;
            stg_d[0].tag    = in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                stg_d[i] = stg_q[i-1];
            end
        end else begin
            vld_d = vld_q;
            stg_d = stg_q;
        end
    end

    // A result is counted in the cycle it actually leaves the pipe
    always_comb begin
        cnt_inc_s = vld_q[LAT-1] & stg_q[LAT-1].unord;
        cnt_sat_s = &nan_cnt_q;
    end

    // NaN counter next state: stall holds, clear beats increment, saturate
    always_comb begin
        nan_cnt_d = nan_cnt_q;
        if (stall) begin
            nan_cnt_d = nan_cnt_q;
        end else if (cnt_clr) begin
            nan_cnt_d = CNT_ZERO;
        end else if (cnt_inc_s && !cnt_sat_s) begin
            nan_cnt_d = nan_cnt_q + CNT_ONE;
        end else begin
            nan_cnt_d = nan_cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= {LAT{1'b0}};
            nan_cnt_q <= CNT_ZERO;
            for (int i = 0; i < LAT; i++) begin
                stg_q[i] <= STAGE_ZERO;
            end
        end else begin
            vld_q     <= vld_d;
            nan_cnt_q <= nan_cnt_d;
            for (int i = 0; i < LAT; i++) begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    // Outputs come straight from the last stage registers
    assign out_valid  = vld_q[LAT-1];
    assign out_result = stg_q[LAT-1].result;
    assign out_lt     = stg_q[LAT-1].lt;
    assign out_eq     = stg_q[LAT-1].eq;
    assign out_gt     = stg_q[LAT-1].gt;
    assign out_unord  = stg_q[LAT-1].unord;
    assign out_tag    = stg_q[LAT-1].tag;
    assign nan_cnt    = nan_cnt_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_compare_pipe
// Directed bench for fp_compare_pipe (WE=11, WF=12, LAT=2). The NaN counter
// is built 4 bits wide so that saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_fp_compare_pipe;

    localparam int WE   = 11;
    localparam int WF   = 12;
    localparam int W    = WE + WF + 3;
    localparam int LAT  = 2;
    localparam int TAGW = 4;
    localparam int CNTW = 4;

    localparam logic [W-1:0] P1   = 26'h13FF000;   // +1.0
    localparam logic [W-1:0] P2   = 26'h1400000;   // +2.0
    localparam logic [W-1:0] M1   = 26'h1BFF000;   // -1.0
    localparam logic [W-1:0] M2   = 26'h1C00000;   // -2.0
    localparam logic [W-1:0] PZ   = 26'h0000000;   // +0
    localparam logic [W-1:0] MZ   = 26'h0800000;   // -0
    localparam logic [W-1:0] PINF = 26'h2000000;   // +inf
    localparam logic [W-1:0] MINF = 26'h2800000;   // -inf
    localparam logic [W-1:0] QNAN = 26'h3000000;   // NaN

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   mode;
        logic         res;
        logic [2:0]   lge;    // {lt, eq, gt}
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            in_valid;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [2:0]      in_mode;
    logic [TAGW-1:0] in_tag;
    logic            cnt_clr;
    logic            out_valid;
    logic            out_result;
    logic            out_lt;
    logic            out_eq;
    logic            out_gt;
    logic            out_unord;
    logic [TAGW-1:0] out_tag;
    logic [CNTW-1:0] nan_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    vec_t rel_tab [14];
    vec_t str_tab [5];

    fp_compare_pipe #(
        .WE   (WE),
        .WF   (WF),
        .LAT  (LAT),
        .TAGW (TAGW),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_lt     (out_lt),
        .out_eq     (out_eq),
        .out_gt     (out_gt),
        .out_unord  (out_unord),
        .out_tag    (out_tag),
        .nan_cnt    (nan_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
        in_a = PZ; in_b = PZ; in_mode = 3'd0; in_tag = 4'd0;
        tick();
        tick();
        vec_cnt++;
        if ({out_valid, out_result, out_lt, out_eq, out_gt, out_unord} !== 6'b000000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {out_valid, out_result, out_lt, out_eq, out_gt, out_unord});
        end
        vec_cnt++;
        if (out_tag !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_tag: got %h expected 0", out_tag);
        end
        vec_cnt++;
        if (nan_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_nan_cnt: got %0d expected 0", nan_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_relations;
        rel_tab[0]  = '{P1,   P2,   3'd0, 1'b1, 3'b100};  // +1 <  +2
        rel_tab[1]  = '{M1,   P1,   3'd1, 1'b1, 3'b100};  // -1 <= +1
        rel_tab[2]  = '{M1,   P1,   3'd3, 1'b0, 3'b100};  // -1 >= +1
        rel_tab[3]  = '{M1,   M1,   3'd1, 1'b1, 3'b010};  // -1 <= -1
        rel_tab[4]  = '{M1,   M1,   3'd3, 1'b1, 3'b010};  // -1 >= -1
        rel_tab[5]  = '{PZ,   MZ,   3'd2, 1'b1, 3'b010};  // +0 == -0
        rel_tab[6]  = '{PINF, P2,   3'd4, 1'b1, 3'b001};  // +inf > +2
        rel_tab[7]  = '{PINF, PINF, 3'd2, 1'b1, 3'b010};  // +inf == +inf
        rel_tab[8]  = '{MINF, MZ,   3'd0, 1'b1, 3'b100};  // -inf < -0
        rel_tab[9]  = '{M2,   M1,   3'd0, 1'b1, 3'b100};  // -2 < -1
        rel_tab[10] = '{P2,   P1,   3'd5, 1'b1, 3'b001};  // +2 != +1
        rel_tab[11] = '{PZ,   P1,   3'd7, 1'b1, 3'b100};  // ordered
        rel_tab[12] = '{PINF, MINF, 3'd1, 1'b0, 3'b001};  // +inf <= -inf
        rel_tab[13] = '{MZ,   P1,   3'd3, 1'b0, 3'b100};  // -0 >= +1
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_a     = rel_tab[i].a;
            in_b     = rel_tab[i].b;
            in_mode  = rel_tab[i].mode;
            in_tag   = 4'(i);
            tick();
            in_valid = 1'b0;
            vec_cnt++;
            if (out_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL rel%0d_early_valid: got %b expected 0", i, out_valid);
            end
            tick();
            vec_cnt++;
            if ({out_valid, out_result, out_lt, out_eq, out_gt, out_unord, out_tag} !==
                {1'b1, rel_tab[i].res, rel_tab[i].lge, 1'b0, 4'(i)}) begin
                err_cnt++;
                $display("FAIL rel%0d: got v=%b r=%b lge=%b u=%b tag=%h expected v=1 r=%b lge=%b u=0 tag=%h",
                         i, out_valid, out_result, {out_lt, out_eq, out_gt}, out_unord, out_tag,
                         rel_tab[i].res, rel_tab[i].lge, 4'(i));
            end
            tick();
        end
    endtask

    task automatic test_nan;
        logic exp_res;
        for (int m = 0; m < 8; m++) begin
            exp_res  = (m == 5) || (m == 6);
            in_valid = 1'b1;
            in_a     = QNAN;
            in_b     = P1;
            in_mode  = 3'(m);
            in_tag   = 4'(m + 8);
            tick();
            in_valid = 1'b0;
            tick();
            vec_cnt++;
            if ({out_valid, out_result, out_lt, out_eq, out_gt, out_unord, out_tag} !==
                {1'b1, exp_res, 3'b000, 1'b1, 4'(m + 8)}) begin
                err_cnt++;
                $display("FAIL nan_mode%0d: got v=%b r=%b lge=%b u=%b tag=%h expected v=1 r=%b lge=000 u=1 tag=%h",
                         m, out_valid, out_result, {out_lt, out_eq, out_gt}, out_unord, out_tag,
                         exp_res, 4'(m + 8));
            end
            tick();
            vec_cnt++;
            if (nan_cnt !== 4'(m + 1)) begin
                err_cnt++;
                $display("FAIL nan_cnt_mode%0d: got %0d expected %0d", m, nan_cnt, m + 1);
            end
        end
        // NaN in B only, ORD relation
        in_valid = 1'b1; in_a = P1; in_b = QNAN; in_mode = 3'd7; in_tag = 4'd3;
        tick();
        in_valid = 1'b0;
        tick();
        vec_cnt++;
        if ({out_valid, out_result, out_unord} !== 3'b101) begin
            err_cnt++;
            $display("FAIL nan_b_ord: got v/r/u=%b expected 101", {out_valid, out_result, out_unord});
        end
        tick();
        vec_cnt++;
        if (nan_cnt !== 4'd9) begin
            err_cnt++;
            $display("FAIL nan_b_cnt: got %0d expected 9", nan_cnt);
        end
    endtask

    task automatic test_stall_stream;
        int   idx;
        int   got;
        int   e;
        logic stall_v;
        int   exp_q [$];
        str_tab[0] = '{P1,   P2, 3'd0, 1'b1, 3'b100};
        str_tab[1] = '{P2,   P1, 3'd0, 1'b0, 3'b001};
        str_tab[2] = '{M1,   M1, 3'd2, 1'b1, 3'b010};
        str_tab[3] = '{PZ,   MZ, 3'd5, 1'b0, 3'b010};
        str_tab[4] = '{PINF, P2, 3'd3, 1'b1, 3'b001};
        idx = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            stall_v = (c >= 2) && (c <= 4);
            if (c == 4) begin
                // op 0 reached the output before the stall and must be held
                vec_cnt++;
                if ({out_valid, out_tag} !== {1'b1, 4'd1}) begin
                    err_cnt++;
                    $display("FAIL stall_hold: got v=%b tag=%h expected v=1 tag=1", out_valid, out_tag);
                end
            end
            stall = stall_v;
            if (idx < 5) begin
                in_valid = 1'b1;
                in_a     = str_tab[idx].a;
                in_b     = str_tab[idx].b;
                in_mode  = str_tab[idx].mode;
                in_tag   = 4'(idx + 1);
            end else begin
                in_valid = 1'b0;
            end
            if (!stall_v && out_valid) begin
                got++;
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL stream_extra: got tag=%h expected no result", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_lt, out_eq, out_gt, out_unord, out_tag} !==
                        {str_tab[e].res, str_tab[e].lge, 1'b0, 4'(e + 1)}) begin
                        err_cnt++;
                        $display("FAIL stream%0d: got r=%b lge=%b u=%b tag=%h expected r=%b lge=%b u=0 tag=%h",
                                 e, out_result, {out_lt, out_eq, out_gt}, out_unord, out_tag,
                                 str_tab[e].res, str_tab[e].lge, 4'(e + 1));
                    end
                end
            end
            if (!stall_v && idx < 5) begin
                exp_q.push_back(idx);
                idx++;
            end
            tick();
        end
        stall = 1'b0;
        in_valid = 1'b0;
        vec_cnt++;
        if (got !== 5 || exp_q.size() !== 0) begin
            err_cnt++;
            $display("FAIL stream_count: got %0d results (%0d pending) expected 5 (0 pending)",
                     got, exp_q.size());
        end
        vec_cnt++;
        if (nan_cnt !== 4'd9) begin
            err_cnt++;
            $display("FAIL stream_nan_cnt: got %0d expected 9", nan_cnt);
        end
    endtask

    task automatic test_reset_inflight;
        in_valid = 1'b1; in_a = QNAN; in_b = P1; in_mode = 3'd6; in_tag = 4'd7;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vec_cnt++;
            if ({out_valid, nan_cnt} !== {1'b0, 4'd0}) begin
                err_cnt++;
                $display("FAIL rst_inflight%0d: got v=%b cnt=%0d expected v=0 cnt=0", c, out_valid, nan_cnt);
            end
            tick();
        end
    endtask

    task automatic test_cnt_clr;
        in_valid = 1'b1; in_a = QNAN; in_b = P2; in_mode = 3'd0; in_tag = 4'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (nan_cnt !== 4'd1) begin
            err_cnt++;
            $display("FAIL clr_pre: got %0d expected 1", nan_cnt);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        // NaN result is at the output; hold it with stall, counter must not move
        stall = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({out_valid, out_unord, nan_cnt} !== {2'b11, 4'd1}) begin
            err_cnt++;
            $display("FAIL stall_cnt: got v=%b u=%b cnt=%0d expected v=1 u=1 cnt=1",
                     out_valid, out_unord, nan_cnt);
        end
        stall = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        vec_cnt++;
        if (nan_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL clr_wins: got %0d expected 0", nan_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int nres;
        int first;
        int last;
        nres  = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 26; c++) begin
            if (out_valid) begin
                vec_cnt++;
                if ({out_unord, out_tag} !== {1'b1, 4'(nres)}) begin
                    err_cnt++;
                    $display("FAIL b2b_res%0d: got u=%b tag=%h expected u=1 tag=%h",
                             nres, out_unord, out_tag, 4'(nres));
                end
                if (first < 0) first = c;
                last = c;
                nres++;
            end
            in_valid = (c < 20);
            in_a     = QNAN;
            in_b     = M1;
            in_mode  = 3'd6;
            in_tag   = 4'(c);
            tick();
        end
        in_valid = 1'b0;
        vec_cnt++;
        if (nres !== 20 || (last - first) !== 19) begin
            err_cnt++;
            $display("FAIL b2b_gapless: got %0d results over %0d cycles expected 20 over 20",
                     nres, last - first + 1);
        end
        vec_cnt++;
        if (nan_cnt !== 4'hF) begin
            err_cnt++;
            $display("FAIL nan_cnt_sat: got %0d expected 15", nan_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_relations();
        test_nan();
        test_stall_stream();
        test_reset_inflight();
        test_cnt_clr();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
